// File: rtl/writeback_stage.sv
// RV64 writeback stage: merges ALU results and load responses into one register_file write port.
// Loads have priority; a one-entry ALU skid buffer with a starvation counter keeps ALU results from waiting forever.
module writeback_stage #(
  parameter int unsigned WORDSIZE     = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [4:0]          alu_rd,
  input  logic [WORDSIZE-1:0] alu_result,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [4:0]          mem_rd,
  input  logic [WORDSIZE-1:0] mem_data,
  input  logic [2:0]          mem_funct3,
  input  logic [2:0]          mem_byte_off,
  output logic                mem_ready,
  output logic                write_en,
  output logic [4:0]          write_addr,
  output logic [WORDSIZE-1:0] write_data,
  output logic                load_err
);

  localparam int unsigned CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned SHAMT_W = 6;

  typedef enum logic [1:0] {SRC_NONE, SRC_MEM, SRC_BUF, SRC_ALU} src_e;

  logic                r_buf_valid;
  logic [4:0]          r_buf_rd;
  logic [WORDSIZE-1:0] r_buf_data;
  logic [CNT_W-1:0]    r_starve_cnt;
  logic                r_write_en;
  logic [4:0]          r_write_addr;
  logic [WORDSIZE-1:0] r_write_data;
  logic                r_load_err;

  logic                w_force;
  logic                w_mem_acc;
  logic                w_alu_acc;
  src_e                w_src;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [WORDSIZE-1:0] w_lane;
  logic [WORDSIZE-1:0] w_load_data;

  logic                w_buf_valid_n;
  logic [4:0]          w_buf_rd_n;
  logic [WORDSIZE-1:0] w_buf_data_n;
  logic [CNT_W-1:0]    w_starve_cnt_n;
  logic                w_write_en_n;
  logic [4:0]          w_write_addr_n;
  logic [WORDSIZE-1:0] w_write_data_n;
  logic                w_load_err_n;

  assign w_force   = r_buf_valid && (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign alu_ready = !r_buf_valid;
  assign mem_ready = !w_force;
  assign w_mem_acc = mem_valid && mem_ready;
  assign w_alu_acc = alu_valid && alu_ready;

  // Winner selection: starved buffer, then memory, then buffer, then fresh ALU result
  always_comb begin
    w_src = SRC_NONE;
    if (w_force)          w_src = SRC_BUF;
    else if (w_mem_acc)   w_src = SRC_MEM;
    else if (r_buf_valid) w_src = SRC_BUF;
    else if (w_alu_acc)   w_src = SRC_ALU;
  end

  // Lane alignment: shift granularity follows the access size
  always_comb begin
    w_shamt = '0;
    case (mem_funct3[1:0])
      2'b00:   w_shamt = {mem_byte_off, 3'b000};
      2'b01:   w_shamt = {mem_byte_off[2:1], 4'b0000};
      2'b10:   w_shamt = {mem_byte_off[2], 5'b00000};
      default: w_shamt = '0;
    endcase
  end

  assign w_lane = mem_data >> w_shamt;

  always_comb begin
    w_load_data = '0;
    case (mem_funct3)
      3'b000:  w_load_data = {{(WORDSIZE-8){w_lane[7]}},   w_lane[7:0]};
      3'b001:  w_load_data = {{(WORDSIZE-16){w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load_data = {{(WORDSIZE-32){w_lane[31]}}, w_lane[31:0]};
      3'b011:  w_load_data = w_lane;
      3'b100:  w_load_data = {{(WORDSIZE-8){1'b0}},  w_lane[7:0]};
      3'b101:  w_load_data = {{(WORDSIZE-16){1'b0}}, w_lane[15:0]};
      3'b110:  w_load_data = {{(WORDSIZE-32){1'b0}}, w_lane[31:0]};
      default: w_load_data = '0;
    endcase
  end

  always_comb begin
    w_buf_valid_n  = r_buf_valid;
    w_buf_rd_n     = r_buf_rd;
    w_buf_data_n   = r_buf_data;
    w_starve_cnt_n = '0;
    w_write_en_n   = 1'b0;
    w_write_addr_n = r_write_addr;
    w_write_data_n = r_write_data;
    w_load_err_n   = 1'b0;

    case (w_src)
      SRC_MEM: begin
        // Illegal load type is consumed without touching the register file
        if (mem_funct3 == 3'b111) begin
          w_load_err_n = 1'b1;
        end else begin
          w_write_en_n   = (mem_rd != 5'd0);
          w_write_addr_n = mem_rd;
          w_write_data_n = w_load_data;
        end
      end
      SRC_BUF: begin
        w_write_en_n   = (r_buf_rd != 5'd0);
        w_write_addr_n = r_buf_rd;
        w_write_data_n = r_buf_data;
        w_buf_valid_n  = 1'b0;
      end
      SRC_ALU: begin
        w_write_en_n   = (alu_rd != 5'd0);
        w_write_addr_n = alu_rd;
        w_write_data_n = alu_result;
      end
      default: ;
    endcase

    if (w_alu_acc && (w_src != SRC_ALU)) begin
      w_buf_valid_n = 1'b1;
      w_buf_rd_n    = alu_rd;
      w_buf_data_n  = alu_result;
    end

    if (r_buf_valid && (w_src != SRC_BUF)) begin
      w_starve_cnt_n = (r_starve_cnt == CNT_W'(STARVE_LIMIT)) ? r_starve_cnt
                                                               : r_starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid  <= 1'b0;
      r_buf_rd     <= '0;
      r_buf_data   <= '0;
      r_starve_cnt <= '0;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_load_err   <= 1'b0;
    end else begin
      r_buf_valid  <= w_buf_valid_n;
      r_buf_rd     <= w_buf_rd_n;
      r_buf_data   <= w_buf_data_n;
      r_starve_cnt <= w_starve_cnt_n;
      r_write_en   <= w_write_en_n;
      r_write_addr <= w_write_addr_n;
      r_write_data <= w_write_data_n;
      r_load_err   <= w_load_err_n;
    end
  end

  assign write_en   = r_write_en;
  assign write_addr = r_write_addr;
  assign write_data = r_write_data;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU path, load extension, collisions,
// starvation override, x0/illegal handling and reset while the skid buffer is full.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_result;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic [2:0]  mem_funct3;
  logic [2:0]  mem_byte_off;
  logic        mem_ready;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [63:0] write_data;
  logic        load_err;

  int n_total;
  int n_bad;

  writeback_stage #(.WORDSIZE(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_funct3(mem_funct3),
    .mem_byte_off(mem_byte_off), .mem_ready(mem_ready),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] rd, input logic [63:0] d, input logic [2:0] f3, input logic [2:0] off);
    mem_valid    = 1'b1;
    mem_rd       = rd;
    mem_data     = d;
    mem_funct3   = f3;
    mem_byte_off = off;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_result = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0; mem_funct3 = '0; mem_byte_off = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_we",   64'(write_en),   64'd0);
    chk("rst_addr", 64'(write_addr), 64'd0);
    chk("rst_data", write_data,      64'd0);
    chk("rst_err",  64'(load_err),   64'd0);
    chk("rst_ardy", 64'(alu_ready),  64'd1);
    chk("rst_mrdy", 64'(mem_ready),  64'd1);

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 64'h1234;
    tick();
    alu_valid = 1'b0;
    chk("alu_we",   64'(write_en),   64'd1);
    chk("alu_addr", 64'(write_addr), 64'd5);
    chk("alu_data", write_data,      64'h0000000000001234);
    tick();
    chk("idle_we",   64'(write_en),   64'd0);
    chk("idle_addr", 64'(write_addr), 64'd5);
    chk("idle_data", write_data,      64'h1234);

    // Load extension
    load(5'd7, 64'h00000000000080FF, 3'b000, 3'd1);
    tick();
    chk("lb_we",   64'(write_en),   64'd1);
    chk("lb_addr", 64'(write_addr), 64'd7);
    chk("lb_data", write_data,      64'hFFFFFFFFFFFFFF80);
    load(5'd7, 64'h00000000000080FF, 3'b101, 3'd0);
    tick();
    chk("lhu_data", write_data, 64'h00000000000080FF);
    load(5'd8, 64'h8123456789ABCDEF, 3'b011, 3'd5);
    tick();
    chk("ld_data", write_data, 64'h8123456789ABCDEF);
    load(5'd8, 64'h8000000100000000, 3'b010, 3'd5);
    tick();
    chk("lw_data", write_data, 64'hFFFFFFFF80000001);
    load(5'd8, 64'hBEEF000000000000, 3'b101, 3'd7);
    tick();
    chk("lhu6_data", write_data, 64'h000000000000BEEF);
    load(5'd8, 64'h00000000FEDCBA98, 3'b110, 3'd3);
    tick();
    chk("lwu_data", write_data, 64'h00000000FEDCBA98);
    load(5'd8, 64'h00AB000000000000, 3'b100, 3'd6);
    tick();
    chk("lbu_data", write_data, 64'h00000000000000AB);
    mem_valid = 1'b0;

    // Collision: memory first, ALU result parked in the buffer
    load(5'd3, 64'h33, 3'b011, 3'd0);
    alu_valid = 1'b1; alu_rd = 5'd4; alu_result = 64'h44;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("col1_addr", 64'(write_addr), 64'd3);
    chk("col1_data", write_data,      64'h33);
    chk("col1_ardy", 64'(alu_ready),  64'd0);
    tick();
    chk("col2_we",   64'(write_en),   64'd1);
    chk("col2_addr", 64'(write_addr), 64'd4);
    chk("col2_data", write_data,      64'h44);
    chk("col2_ardy", 64'(alu_ready),  64'd1);

    // Starvation: memory wins 4 times, then the buffer is forced through
    load(5'd3, 64'h33, 3'b011, 3'd0);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_result = 64'h99;
    tick();
    alu_valid = 1'b0;
    chk("stv0_addr", 64'(write_addr), 64'd3);
    for (int i = 0; i < 4; i++) begin
      chk("stv_mrdy", 64'(mem_ready), 64'd1);
      load(5'(10 + i), 64'(100 + i), 3'b011, 3'd0);
      tick();
      chk("stv_addr", 64'(write_addr), 64'(10 + i));
    end
    chk("stv_mrdy_lo", 64'(mem_ready), 64'd0);
    load(5'd20, 64'h200, 3'b011, 3'd0);
    tick();
    chk("stv_buf_addr", 64'(write_addr), 64'd9);
    chk("stv_buf_data", write_data,      64'h99);
    chk("stv_mrdy_hi",  64'(mem_ready),  64'd1);
    tick();
    mem_valid = 1'b0;
    chk("stv_mem_addr", 64'(write_addr), 64'd20);
    chk("stv_mem_data", write_data,      64'h200);

    // x0 write suppressed, addr/data still update
    alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 64'h55;
    tick();
    alu_valid = 1'b0;
    chk("x0_we",   64'(write_en),   64'd0);
    chk("x0_addr", 64'(write_addr), 64'd0);
    chk("x0_data", write_data,      64'h55);

    // Illegal load type
    load(5'd6, 64'h66, 3'b111, 3'd0);
    tick();
    mem_valid = 1'b0;
    chk("ill_err", 64'(load_err), 64'd1);
    chk("ill_we",  64'(write_en), 64'd0);
    tick();
    chk("ill_err_clr", 64'(load_err), 64'd0);

    // Reset while the buffer holds a result
    load(5'd11, 64'h11, 3'b011, 3'd0);
    alu_valid = 1'b1; alu_rd = 5'd12; alu_result = 64'hCC;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("rm_ardy_pre", 64'(alu_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_we",   64'(write_en),   64'd0);
    chk("rm_addr", 64'(write_addr), 64'd0);
    chk("rm_data", write_data,      64'd0);
    chk("rm_err",  64'(load_err),   64'd0);
    chk("rm_ardy", 64'(alu_ready),  64'd1);
    chk("rm_mrdy", 64'(mem_ready),  64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rm_nowrite_we",   64'(write_en), 64'd0);
      chk("rm_nowrite_data", write_data,    64'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
